dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 215 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the core MEM stage: one request in flight at a
// time, fixed-latency response, little-endian byte/half/word access with
// sign-extended loads and an error response for illegal accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [1:0]  ReqSize,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        AddrErr,
    output logic        Stall
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [3:0]  cnt;
    logic [3:0]  cntNext;

    // Request fields captured at acceptance; the core may change its
    // request lines afterwards without disturbing the in-flight access.
    logic        writeQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [1:0]  sizeQ;

    // Response payload registered on the edge that enters RESP.
    logic [31:0] respDataQ;
    logic        errQ;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enterResp;

    logic        opWrite;
    logic [31:0] opAddr;
    logic [31:0] opWData;
    logic [1:0]  opSize;
    logic        inRange;
    logic        opErr;
    logic [IDX_W-1:0] opIdx;
    logic [3:0]  laneEn;
    logic [31:0] laneData;
    logic [31:0] rdWord;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    logic [31:0] loadResult;
    logic        commit;

    // State register, wait counter, captured request and response payload.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            writeQ    <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            sizeQ     <= '0;
            respDataQ <= '0;
            errQ      <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
            if (accept) begin
                writeQ <= ReqWrite;
                addrQ  <= ReqAddr;
                wdataQ <= ReqWData;
                sizeQ  <= ReqSize;
            end
            if (enterResp) begin
                respDataQ <= (opErr || opWrite) ? 32'd0 : loadResult;
                errQ      <= opErr;
            end
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one RESP cycle.
    always_comb begin
        nextState = state;
        cntNext   = cnt;
        accept    = 1'b0;
        enterResp = 1'b0;
        case (state)
            IDLE: begin
                if (ReqValid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        nextState = RESP;
                        enterResp = 1'b1;
                    end else begin
                        nextState = WAIT;
                        cntNext   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    nextState = RESP;
                    enterResp = 1'b1;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // The operation that completes this cycle: straight from the request
    // lines when it is accepted and finishes on the same edge, otherwise
    // from the captured copy.
    always_comb begin
        if (state == IDLE) begin
            opWrite = ReqWrite;
            opAddr  = ReqAddr;
            opWData = ReqWData;
            opSize  = ReqSize;
        end else begin
            opWrite = writeQ;
            opAddr  = addrQ;
            opWData = wdataQ;
            opSize  = sizeQ;
        end
    end

    // Legality check, lane enables for stores and lane extraction for loads.
    always_comb begin
        inRange  = ({2'b00, opAddr[31:2]} < 32'(DEPTH_WORDS));
        opErr    = 1'b0;
        laneEn   = 4'b0000;
        laneData = opWData;
        case (opSize)
            SIZE_WORD: begin
                opErr    = (opAddr[1:0] != 2'b00);
                laneEn   = 4'b1111;
                laneData = opWData;
            end
            SIZE_HALF: begin
                opErr    = opAddr[0];
                laneEn   = opAddr[1] ? 4'b1100 : 4'b0011;
                laneData = {2{opWData[15:0]}};
            end
            SIZE_BYTE: begin
                laneEn   = 4'b0001 << opAddr[1:0];
                laneData = {4{opWData[7:0]}};
            end
            default: begin
                opErr = 1'b1;
            end
        endcase
        if (!inRange) begin
            opErr = 1'b1;
        end

        opIdx  = opAddr[IDX_W+1:2];
        rdWord = mem[opIdx];
        rdByte = rdWord[{opAddr[1:0], 3'b000} +: 8];
        rdHalf = opAddr[1] ? rdWord[31:16] : rdWord[15:0];

        case (opSize)
            SIZE_HALF: loadResult = {{16{rdHalf[15]}}, rdHalf};
            SIZE_BYTE: loadResult = {{24{rdByte[7]}}, rdByte};
            default:   loadResult = rdWord;
        endcase

        commit = enterResp && opWrite && !opErr && !Reset;
    end

    // Storage: stores land on the edge that enters RESP; never cleared.
    always_ff @(posedge Clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (laneEn[b]) begin
                    mem[opIdx][8*b +: 8] <= laneData[8*b +: 8];
                end
            end
        end
    end

    // Handshake and response outputs; the payload is forced to zero
    // outside the response strobe and everything is quiet under reset.
    always_comb begin
        ReqReady  = (state == IDLE) && !Reset;
        Stall     = (state != IDLE) && !Reset;
        RespValid = (state == RESP) && !Reset;
        RespData  = RespValid ? respDataQ : 32'd0;
        AddrErr   = RespValid && errQ;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: a byte-array reference
// model predicts every response, a monitor pops and compares them.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    localparam int RESP_OFFSET = (LAT == 1) ? 0 : LAT;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic [1:0]  ReqSize;
    logic        RespValid;
    logic [31:0] RespData;
    logic        AddrErr;
    logic        Stall;

    logic        lValid;
    logic        lReady;
    logic        lRespValid;
    logic [31:0] lRespData;
    logic        lAddrErr;
    logic        lStall;

    always #5 Clk = ~Clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqSize(ReqSize),
        .RespValid(RespValid), .RespData(RespData), .AddrErr(AddrErr),
        .Stall(Stall)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dutL1 (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(lValid), .ReqReady(lReady), .ReqWrite(1'b0),
        .ReqAddr(32'd0), .ReqWData(32'd0), .ReqSize(2'b00),
        .RespValid(lRespValid), .RespData(lRespData), .AddrErr(lAddrErr),
        .Stall(lStall)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cycle;
    } expT;

    expT        expQ[$];
    expT        monE;
    logic [7:0] modelBytes [DEPTH*4];
    int         total = 0;
    int         bad = 0;
    int         negCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at negedge %0d", name, act, req, negCount);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    // Reference: memory as a flat byte array, loads assembled byte by byte
    // and sign-extended through a signed integer.
    function automatic void modelAccess(input logic write, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [1:0] size,
                                        output logic err, output logic [31:0] data);
        int nBytes;
        int base;
        int sv;
        logic [31:0] v;
        err = (size == 2'd3) || (size == 2'd0 && addr[1:0] != 2'd0) ||
              (size == 2'd1 && addr[0]) || ((addr >> 2) >= DEPTH);
        data = 32'd0;
        if (err) return;
        nBytes = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
        base = int'(addr);
        if (write) begin
            for (int i = 0; i < nBytes; i++) modelBytes[base + i] = wdata[8*i +: 8];
            return;
        end
        v = 32'd0;
        for (int i = 0; i < nBytes; i++) v[8*i +: 8] = modelBytes[base + i];
        if (nBytes == 4) data = v;
        else if (nBytes == 2) begin sv = $signed(v[15:0]); data = sv; end
        else begin sv = $signed(v[7:0]); data = sv; end
    endfunction

    // Issue one request, push its predicted response, scramble the request
    // lines while busy and check the stall window around it.
    task automatic applyStimulus(input logic write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size);
        int   guard;
        int   respAt;
        expT  e;
        ReqWrite = write; ReqAddr = addr; ReqWData = wdata; ReqSize = size;
        ReqValid = 1'b1;
        guard = 0;
        while (!ReqReady && guard < 20) begin tick(); guard++; end
        if (!ReqReady) begin
            total++; bad++;
            $display("[TB] FAIL readyTimeout actual=0 required=1");
            ReqValid = 1'b0;
            return;
        end
        respAt = negCount + 1 + RESP_OFFSET;
        modelAccess(write, addr, wdata, size, e.err, e.data);
        e.cycle = respAt;
        expQ.push_back(e);
        while (negCount < respAt) begin
            tick();
            checkOutput("stallBusy", {31'b0, Stall}, 32'd1);
            if (negCount < respAt) begin
                ReqValid = 1'b1; ReqWrite = 1'($urandom); ReqAddr = $urandom;
                ReqWData = $urandom; ReqSize = 2'($urandom);
            end else begin
                ReqValid = 1'b0;
            end
        end
        tick();
        checkOutput("stallRelease", {31'b0, Stall}, 32'd0);
        checkOutput("readyAgain", {31'b0, ReqReady}, 32'd1);
    endtask

    // Monitor: compare every response strobe with the scoreboard head.
    always @(negedge Clk) begin
        negCount++;
        if (expQ.size() > 0 && negCount > expQ[0].cycle) begin
            total++; bad++;
            $display("[TB] FAIL respTimeout actual=none required=resp@%0d", expQ[0].cycle);
            expQ.delete(0);
        end
        if (RespValid) begin
            if (expQ.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL unexpectedResp actual=1 required=0 data=%h", RespData);
            end else begin
                monE = expQ.pop_front();
                checkOutput("respData", RespData, monE.data);
                checkOutput("respErr", {31'b0, AddrErr}, {31'b0, monE.err});
                checkOutput("respCycle", 32'(negCount), 32'(monE.cycle));
            end
        end else begin
            checkOutput("idleData", RespData, 32'd0);
            checkOutput("idleErr", {31'b0, AddrErr}, 32'd0);
        end
    end

    int accepts;
    int pulses;

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0;
        ReqWData = '0; ReqSize = '0; lValid = 1'b0;
        repeat (3) tick();
        checkOutput("resetRespValid", {31'b0, RespValid}, 32'd0);
        checkOutput("resetStall", {31'b0, Stall}, 32'd0);
        Reset = 1'b0;
        tick();
        checkOutput("postResetReady", {31'b0, ReqReady}, 32'd1);

        // Fill every word so the model and storage agree from here on.
        for (int w = 0; w < DEPTH; w++) applyStimulus(1'b1, 32'(w * 4), $urandom, 2'd0);

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 2'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, 2'd0);

        applyStimulus(1'b1, 32'h10, 32'h11223344, 2'd0);
        applyStimulus(1'b1, 32'h13, 32'h00000080, 2'd2);
        applyStimulus(1'b0, 32'h10, 32'h0, 2'd0);
        applyStimulus(1'b0, 32'h13, 32'h0, 2'd2);

        applyStimulus(1'b1, 32'h10, 32'h80017FFF, 2'd0);
        applyStimulus(1'b0, 32'h12, 32'h0, 2'd1);
        applyStimulus(1'b0, 32'h10, 32'h0, 2'd1);

        applyStimulus(1'b0, 32'h11, 32'h0, 2'd0);
        applyStimulus(1'b1, 32'h13, 32'hAAAA5555, 2'd1);
        applyStimulus(1'b1, 32'(DEPTH * 4), 32'h12345678, 2'd0);
        applyStimulus(1'b0, 32'(DEPTH * 4), 32'h0, 2'd0);
        applyStimulus(1'b1, 32'h10, 32'hCAFEF00D, 2'd3);
        applyStimulus(1'b0, 32'h10, 32'h0, 2'd0);

        // Reset during WAIT must drop the pending store.
        ReqWrite = 1'b1; ReqAddr = 32'h20; ReqWData = 32'h5; ReqSize = 2'd0; ReqValid = 1'b1;
        tick();
        ReqValid = 1'b0;
        Reset = 1'b1;
        tick();
        checkOutput("abortRespValid", {31'b0, RespValid}, 32'd0);
        checkOutput("abortStall", {31'b0, Stall}, 32'd0);
        Reset = 1'b0;
        tick();
        checkOutput("abortReady", {31'b0, ReqReady}, 32'd1);
        repeat (4) tick();
        applyStimulus(1'b0, 32'h20, 32'h0, 2'd0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH * 4 + 3));
            applyStimulus(1'($urandom), a, $urandom, 2'($urandom_range(0, 3)));
        end

        // Back-to-back acceptance with the single-cycle-latency instance.
        accepts = 0; pulses = 0;
        lValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (lReady && lValid) accepts++;
            if (lRespValid) begin
                pulses++;
                checkOutput("l1RespErr", {31'b0, lAddrErr}, 32'd0);
            end
            tick();
        end
        lValid = 1'b0;
        checkOutput("l1Accepts", 32'(accepts), 32'd5);
        checkOutput("l1Pulses", 32'(pulses), 32'd5);

        repeat (LAT + 4) tick();
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
